// File: rtl/rf_issue_sequencer_if.sv
// Fetch/register-file/consumer signal bundle for rf_issue_sequencer.
// master = sequencer side, slave = fetch/register-file/consumer side.
interface rf_issue_sequencer_if #(
  parameter int unsigned DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_instr;
  logic              rf_en;
  logic [2:0]        rf_opcode;
  logic [2:0]        rf_reg1;
  logic [2:0]        rf_reg2;
  logic [2:0]        rf_reg3;
  logic [DATA_W-1:0] rf_imm;
  logic [DATA_W-1:0] rf_result;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_err;

  modport master (
    input  in_valid, in_instr, rf_result, out_ready,
    output in_ready, rf_en, rf_opcode, rf_reg1, rf_reg2, rf_reg3, rf_imm,
           out_valid, out_result, out_err
  );

  modport slave (
    output in_valid, in_instr, rf_result, out_ready,
    input  in_ready, rf_en, rf_opcode, rf_reg1, rf_reg2, rf_reg3, rf_imm,
           out_valid, out_result, out_err
  );
endinterface

// File: rtl/rf_issue_sequencer.sv
// Issues one ALU instruction at a time to the 8x16 register file and returns its result.
// Optional RF_SEQ_STATS_EN adds retired/illegal instruction counters.
module rf_issue_sequencer #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned RF_LATENCY = 1,
  parameter int unsigned IMM_SEXT   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  rf_issue_sequencer_if.master bus
`ifdef RF_SEQ_STATS_EN
  ,
  output logic [15:0]          retired_cnt,
  output logic [15:0]          illegal_cnt
`endif
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned IMM_W = 7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [2:0] OP_ADDI      = 3'b001;
  localparam logic [2:0] OP_SUBI      = 3'b010;
  localparam logic [2:0] OP_MAX_LEGAL = 3'b011;

  logic [1:0]        state_q,      state_d;
  logic [CNT_W-1:0]  cnt_q,        cnt_d;
  logic              in_ready_q,   in_ready_d;
  logic              rf_en_q,      rf_en_d;
  logic [2:0]        rf_opcode_q,  rf_opcode_d;
  logic [2:0]        rf_reg1_q,    rf_reg1_d;
  logic [2:0]        rf_reg2_q,    rf_reg2_d;
  logic [2:0]        rf_reg3_q,    rf_reg3_d;
  logic [DATA_W-1:0] rf_imm_q,     rf_imm_d;
  logic              out_valid_q,  out_valid_d;
  logic [DATA_W-1:0] out_result_q, out_result_d;
  logic              out_err_q,    out_err_d;

  // Instruction word decode
  logic [2:0]        dec_op_c;
  logic [2:0]        dec_rd_c;
  logic [2:0]        dec_rs1_c;
  logic [2:0]        dec_rs2_c;
  logic [IMM_W-1:0]  dec_imm7_c;
  logic [DATA_W-1:0] dec_imm_c;
  logic              dec_is_imm_c;
  logic              dec_legal_c;
  logic              accept_c;
  logic              out_hs_c;

  assign dec_op_c     = bus.in_instr[15:13];
  assign dec_rd_c     = bus.in_instr[12:10];
  assign dec_rs1_c    = bus.in_instr[9:7];
  assign dec_rs2_c    = bus.in_instr[6:4];
  assign dec_imm7_c   = bus.in_instr[6:0];
  assign dec_imm_c    = (IMM_SEXT != 0)
                        ? {{(DATA_W-IMM_W){dec_imm7_c[IMM_W-1]}}, dec_imm7_c}
                        : {{(DATA_W-IMM_W){1'b0}}, dec_imm7_c};
  assign dec_is_imm_c = (dec_op_c == OP_ADDI) || (dec_op_c == OP_SUBI);
  assign dec_legal_c  = (dec_op_c <= OP_MAX_LEGAL);

  assign accept_c = (state_q == ST_IDLE) && bus.in_valid && in_ready_q;
  assign out_hs_c = out_valid_q && bus.out_ready;

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    in_ready_d   = 1'b0;
    rf_en_d      = 1'b0;
    rf_opcode_d  = rf_opcode_q;
    rf_reg1_d    = rf_reg1_q;
    rf_reg2_d    = rf_reg2_q;
    rf_reg3_d    = rf_reg3_q;
    rf_imm_d     = rf_imm_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_err_d    = out_err_q;

    case (state_q)
      ST_IDLE: begin
        in_ready_d = 1'b1;
        if (accept_c) begin
          in_ready_d  = 1'b0;
          rf_opcode_d = dec_op_c;
          rf_reg1_d   = dec_rd_c;
          rf_reg2_d   = dec_rs1_c;
          rf_reg3_d   = dec_is_imm_c ? 3'd0 : dec_rs2_c;
          rf_imm_d    = dec_is_imm_c ? dec_imm_c : '0;
          if (dec_legal_c) begin
            state_d   = ST_ISSUE;
            rf_en_d   = 1'b1;
            out_err_d = 1'b0;
          end else begin
            // Illegal opcode never reaches the register file
            state_d      = ST_RESP;
            out_valid_d  = 1'b1;
            out_err_d    = 1'b1;
            out_result_d = '0;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = CNT_W'(RF_LATENCY - 1);
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d      = ST_RESP;
          out_valid_d  = 1'b1;
          out_result_d = bus.rf_result;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (out_hs_c) begin
          state_d     = ST_IDLE;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
          rf_opcode_d = 3'd0;
          rf_reg1_d   = 3'd0;
          rf_reg2_d   = 3'd0;
          rf_reg3_d   = 3'd0;
          rf_imm_d    = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      in_ready_q   <= 1'b0;
      rf_en_q      <= 1'b0;
      rf_opcode_q  <= 3'd0;
      rf_reg1_q    <= 3'd0;
      rf_reg2_q    <= 3'd0;
      rf_reg3_q    <= 3'd0;
      rf_imm_q     <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      in_ready_q   <= in_ready_d;
      rf_en_q      <= rf_en_d;
      rf_opcode_q  <= rf_opcode_d;
      rf_reg1_q    <= rf_reg1_d;
      rf_reg2_q    <= rf_reg2_d;
      rf_reg3_q    <= rf_reg3_d;
      rf_imm_q     <= rf_imm_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_err_q    <= out_err_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.rf_en      = rf_en_q;
  assign bus.rf_opcode  = rf_opcode_q;
  assign bus.rf_reg1    = rf_reg1_q;
  assign bus.rf_reg2    = rf_reg2_q;
  assign bus.rf_reg3    = rf_reg3_q;
  assign bus.rf_imm     = rf_imm_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_err    = out_err_q;

`ifdef RF_SEQ_STATS_EN
  // Retired/illegal counters advance on the result handshake and wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_cnt <= 16'd0;
      illegal_cnt <= 16'd0;
    end else if (out_hs_c) begin
      if (out_err_q) illegal_cnt <= illegal_cnt + 16'd1;
      else           retired_cnt <= retired_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rf_issue_sequencer.sv
// Bench for rf_issue_sequencer: two instances (latency 1 sign-extend, latency 4 zero-extend)
// each with a small register-file model; results checked through per-instance scoreboards.
module tb_rf_issue_sequencer;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_issue_sequencer_if #(.DATA_W(DW)) ia ();
  rf_issue_sequencer_if #(.DATA_W(DW)) ib ();

`ifdef RF_SEQ_STATS_EN
  logic [15:0] ret_a, ill_a, ret_b, ill_b;
`endif

  rf_issue_sequencer #(.DATA_W(DW), .RF_LATENCY(1), .IMM_SEXT(1)) dut_a (
    .clk(clk), .rst(rst), .bus(ia)
`ifdef RF_SEQ_STATS_EN
    , .retired_cnt(ret_a), .illegal_cnt(ill_a)
`endif
  );

  rf_issue_sequencer #(.DATA_W(DW), .RF_LATENCY(4), .IMM_SEXT(0)) dut_b (
    .clk(clk), .rst(rst), .bus(ib)
`ifdef RF_SEQ_STATS_EN
    , .retired_cnt(ret_b), .illegal_cnt(ill_b)
`endif
  );

  int total = 0;
  int bad   = 0;
  logic [16:0] sb_a[$];
  logic [16:0] sb_b[$];

  // Register file contents: r[i] = i + 1
  function automatic logic [15:0] rval(input logic [2:0] r);
    return 16'(r) + 16'd1;
  endfunction

  function automatic logic [15:0] ext7(input logic [6:0] i, input bit sext);
    return sext ? {{9{i[6]}}, i} : {9'd0, i};
  endfunction

  // Expected {err, result} for an instruction word
  function automatic logic [16:0] model(input logic [15:0] w, input bit sext);
    logic [15:0] a, b, i;
    a = rval(w[9:7]);
    b = rval(w[6:4]);
    i = ext7(w[6:0], sext);
    case (w[15:13])
      3'd0:    return {1'b0, a + b};
      3'd1:    return {1'b0, a + i};
      3'd2:    return {1'b0, a - i};
      3'd3:    return {1'b0, a - b};
      default: return {1'b1, 16'h0000};
    endcase
  endfunction

  function automatic logic [15:0] rf_calc(input logic [2:0] op, input logic [2:0] rs1,
                                          input logic [2:0] rs2, input logic [15:0] imm);
    case (op)
      3'd0:    return rval(rs1) + rval(rs2);
      3'd1:    return rval(rs1) + imm;
      3'd2:    return rval(rs1) - imm;
      default: return rval(rs1) - rval(rs2);
    endcase
  endfunction

  // Register-file models: result is valid only in the cycle RF_LATENCY after rf_en
  int          cd_a = -1;
  int          cd_b = -1;
  logic [15:0] res_a = 16'h0;
  logic [15:0] res_b = 16'h0;

  always @(posedge clk) begin
    if (rst) cd_a = -1;
    else if (ia.rf_en) begin
      cd_a  = 0;
      res_a = rf_calc(ia.rf_opcode, ia.rf_reg2, ia.rf_reg3, ia.rf_imm);
    end else if (cd_a >= 0) cd_a = cd_a - 1;
    #1 ia.rf_result = (cd_a == 0) ? res_a : 16'hDEAD;
  end

  always @(posedge clk) begin
    if (rst) cd_b = -1;
    else if (ib.rf_en) begin
      cd_b  = 3;
      res_b = rf_calc(ib.rf_opcode, ib.rf_reg2, ib.rf_reg3, ib.rf_imm);
    end else if (cd_b >= 0) cd_b = cd_b - 1;
    #1 ib.rf_result = (cd_b == 0) ? res_b : 16'hDEAD;
  end

  task automatic test_reset();
    bit seen;
    rst = 1'b1;
    ia.in_valid = 1'b0; ia.in_instr = 16'h0; ia.out_ready = 1'b1;
    ib.in_valid = 1'b0; ib.in_instr = 16'h0; ib.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (ia.in_ready !== 1'b0 || ib.in_ready !== 1'b0) begin bad++;
      $display("FAIL reset_in_ready: got a=%b b=%b want 0", ia.in_ready, ib.in_ready); end
    total++; if (ia.rf_en !== 1'b0 || ia.out_valid !== 1'b0 || ib.out_valid !== 1'b0) begin bad++;
      $display("FAIL reset_outputs: got rf_en=%b ova=%b ovb=%b want 0", ia.rf_en, ia.out_valid, ib.out_valid); end
    rst = 1'b0;
    #1;
    total++; if (ia.in_ready !== 1'b0) begin bad++;
      $display("FAIL release_ready_before_edge: got %b want 0", ia.in_ready); end
    @(negedge clk);
    total++; if (ia.in_ready !== 1'b1 || ib.in_ready !== 1'b1) begin bad++;
      $display("FAIL release_ready: got a=%b b=%b want 1", ia.in_ready, ib.in_ready); end
    total++; if (ia.rf_opcode !== 3'd0 || ib.rf_opcode !== 3'd0) begin bad++;
      $display("FAIL reset_opcode: got a=%0d b=%0d want 0", ia.rf_opcode, ib.rf_opcode); end
    // B goes into WAIT while A sits in ISSUE, then reset hits both
    ib.in_instr = 16'h6720; ib.in_valid = 1'b1;
    @(negedge clk);
    ib.in_valid = 1'b0; ia.in_instr = 16'h0530; ia.in_valid = 1'b1;
    @(negedge clk);
    ia.in_valid = 1'b0;
    total++; if (ia.rf_en !== 1'b1) begin bad++;
      $display("FAIL midop_issue: got rf_en=%b want 1", ia.rf_en); end
    #2 rst = 1'b1;
    #1;
    total++; if (ia.rf_en !== 1'b0 || ia.in_ready !== 1'b0 || ib.in_ready !== 1'b0 || ib.out_valid !== 1'b0) begin bad++;
      $display("FAIL async_drop: got rf_en=%b rdya=%b rdyb=%b ovb=%b want 0", ia.rf_en, ia.in_ready, ib.in_ready, ib.out_valid); end
    total++; if (ia.rf_opcode !== 3'd0 || ib.rf_opcode !== 3'd0) begin bad++;
      $display("FAIL async_decode_clear: got a=%0d b=%0d want 0", ia.rf_opcode, ib.rf_opcode); end
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ia.out_valid || ib.out_valid || ia.rf_en || ib.rf_en) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++;
      $display("FAIL dropped_instr: got activity=%b want 0", seen); end
    total++; if (ia.in_ready !== 1'b1 || ib.in_ready !== 1'b1 || ib.rf_opcode !== 3'd0) begin bad++;
      $display("FAIL post_reset_idle: got rdya=%b rdyb=%b op=%0d want 1 1 0", ia.in_ready, ib.in_ready, ib.rf_opcode); end
  endtask

  task automatic test_add();
    logic [16:0] exp;
    sb_a.delete();
    @(negedge clk);
    ia.in_instr = 16'h0530; ia.in_valid = 1'b1; ia.out_ready = 1'b1;
    total++; if (ia.in_ready !== 1'b1) begin bad++;
      $display("FAIL add_accept: got in_ready=%b want 1", ia.in_ready); end
    sb_a.push_back(model(16'h0530, 1'b1));
    @(negedge clk);
    ia.in_valid = 1'b0;
    total++; if (ia.rf_en !== 1'b1 || ia.out_valid !== 1'b0 || ia.in_ready !== 1'b0) begin bad++;
      $display("FAIL add_issue: got rf_en=%b out_valid=%b in_ready=%b want 1 0 0", ia.rf_en, ia.out_valid, ia.in_ready); end
    total++; if ({ia.rf_opcode, ia.rf_reg1, ia.rf_reg2, ia.rf_reg3} !== {3'd0, 3'd1, 3'd2, 3'd3} || ia.rf_imm !== 16'h0) begin bad++;
      $display("FAIL add_fields: got op=%0d r1=%0d r2=%0d r3=%0d imm=%h want 0 1 2 3 0000",
               ia.rf_opcode, ia.rf_reg1, ia.rf_reg2, ia.rf_reg3, ia.rf_imm); end
    @(negedge clk);
    total++; if (ia.rf_en !== 1'b0 || ia.out_valid !== 1'b0) begin bad++;
      $display("FAIL add_wait: got rf_en=%b out_valid=%b want 0 0", ia.rf_en, ia.out_valid); end
    @(negedge clk);
    total++; if (ia.out_valid !== 1'b1) begin bad++;
      $display("FAIL add_latency: got out_valid=%b want 1", ia.out_valid); end
    if (ia.out_valid === 1'b1 && sb_a.size() > 0) begin
      exp = sb_a.pop_front();
      total++; if ({ia.out_err, ia.out_result} !== exp) begin bad++;
        $display("FAIL add_result: got err=%b res=%h want err=%b res=%h", ia.out_err, ia.out_result, exp[16], exp[15:0]); end
    end
    total++; if (ia.rf_reg1 !== 3'd1) begin bad++;
      $display("FAIL add_hold: got reg1=%0d want 1", ia.rf_reg1); end
    @(negedge clk);
    total++; if (ia.out_valid !== 1'b0 || ia.in_ready !== 1'b1 || ia.rf_reg1 !== 3'd0) begin bad++;
      $display("FAIL add_idle: got out_valid=%b in_ready=%b reg1=%0d want 0 1 0", ia.out_valid, ia.in_ready, ia.rf_reg1); end
  endtask

  task automatic test_illegal();
    logic [16:0] exp;
    sb_a.delete();
    @(negedge clk);
    ia.in_instr = 16'hA123; ia.in_valid = 1'b1;
    total++; if (ia.in_ready !== 1'b1) begin bad++;
      $display("FAIL ill_accept: got in_ready=%b want 1", ia.in_ready); end
    sb_a.push_back(model(16'hA123, 1'b1));
    @(negedge clk);
    ia.in_valid = 1'b0;
    total++; if (ia.out_valid !== 1'b1 || ia.rf_en !== 1'b0) begin bad++;
      $display("FAIL ill_latency: got out_valid=%b rf_en=%b want 1 0", ia.out_valid, ia.rf_en); end
    if (ia.out_valid === 1'b1 && sb_a.size() > 0) begin
      exp = sb_a.pop_front();
      total++; if ({ia.out_err, ia.out_result} !== exp) begin bad++;
        $display("FAIL ill_result: got err=%b res=%h want err=%b res=%h", ia.out_err, ia.out_result, exp[16], exp[15:0]); end
    end
    @(negedge clk);
    total++; if (ia.out_valid !== 1'b0 || ia.in_ready !== 1'b1 || ia.rf_en !== 1'b0) begin bad++;
      $display("FAIL ill_idle: got out_valid=%b in_ready=%b rf_en=%b want 0 1 0", ia.out_valid, ia.in_ready, ia.rf_en); end
`ifdef RF_SEQ_STATS_EN
    total++; if (ill_a !== 16'd1 || ret_a !== 16'd1) begin bad++;
      $display("FAIL ill_stats: got illegal=%0d retired=%0d want 1 1", ill_a, ret_a); end
`endif
  endtask

  task automatic test_backpressure();
    logic [16:0] exp;
    bit found;
    sb_a.delete();
    @(negedge clk);
    ia.in_instr = 16'h6F90; ia.in_valid = 1'b1; ia.out_ready = 1'b0;
    total++; if (ia.in_ready !== 1'b1) begin bad++;
      $display("FAIL bp_accept: got in_ready=%b want 1", ia.in_ready); end
    sb_a.push_back(model(16'h6F90, 1'b1));
    exp = sb_a[0];
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      ia.in_instr = 16'h0530;
      if (ia.out_valid === 1'b1) found = 1'b1;
    end
    total++; if (!found) begin bad++;
      $display("FAIL bp_timeout: got out_valid=%b want 1 within 10 cycles", ia.out_valid); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total++; if (ia.out_valid !== 1'b1 || {ia.out_err, ia.out_result} !== exp) begin bad++;
        $display("FAIL bp_hold: got valid=%b err=%b res=%h want 1 %b %h", ia.out_valid, ia.out_err, ia.out_result, exp[16], exp[15:0]); end
      total++; if (ia.in_ready !== 1'b0 || ia.rf_en !== 1'b0) begin bad++;
        $display("FAIL bp_stall_in: got in_ready=%b rf_en=%b want 0 0", ia.in_ready, ia.rf_en); end
    end
    ia.out_ready = 1'b1; ia.in_valid = 1'b0;
    if (sb_a.size() > 0) begin
      exp = sb_a.pop_front();
      total++; if ({ia.out_err, ia.out_result} !== exp) begin bad++;
        $display("FAIL bp_result: got err=%b res=%h want err=%b res=%h", ia.out_err, ia.out_result, exp[16], exp[15:0]); end
    end
    @(negedge clk);
    total++; if (ia.out_valid !== 1'b0 || ia.in_ready !== 1'b1) begin bad++;
      $display("FAIL bp_release: got out_valid=%b in_ready=%b want 0 1", ia.out_valid, ia.in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w [2];
    logic [16:0] exp;
    int acc [2];
    int idx;
    int got;
    w[0] = 16'h6720; w[1] = 16'h4A03;
    acc[0] = 0; acc[1] = 0;
    idx = 0; got = 0;
    sb_b.delete();
    ib.out_ready = 1'b1;
    for (int k = 0; k < 40 && got < 2; k++) begin
      @(negedge clk);
      if (ib.out_valid === 1'b1) begin
        if (sb_b.size() > 0) begin
          exp = sb_b.pop_front();
          total++; if ({ib.out_err, ib.out_result} !== exp) begin bad++;
            $display("FAIL b2b_result%0d: got err=%b res=%h want err=%b res=%h", got, ib.out_err, ib.out_result, exp[16], exp[15:0]); end
        end
        got++;
      end
      if (idx < 2) begin
        ib.in_valid = 1'b1; ib.in_instr = w[idx];
        if (ib.in_ready === 1'b1) begin
          sb_b.push_back(model(w[idx], 1'b0));
          acc[idx] = k;
          idx++;
        end
      end else begin
        ib.in_valid = 1'b0;
      end
    end
    ib.in_valid = 1'b0;
    total++; if (got !== 2) begin bad++;
      $display("FAIL b2b_count: got %0d results want 2", got); end
    total++; if (acc[1] - acc[0] !== 7) begin bad++;
      $display("FAIL b2b_spacing: got %0d cycles want 7", acc[1] - acc[0]); end
    @(negedge clk);
`ifdef RF_SEQ_STATS_EN
    total++; if (ret_b !== 16'd2 || ill_b !== 16'd0) begin bad++;
      $display("FAIL b2b_stats: got retired=%0d illegal=%0d want 2 0", ret_b, ill_b); end
`endif
  endtask

  task automatic test_imm();
    logic [16:0] exp;
    int lat;
    sb_a.delete(); sb_b.delete();
    // Sign-extending instance
    @(negedge clk);
    ia.in_instr = 16'h2AFF; ia.in_valid = 1'b1;
    sb_a.push_back(model(16'h2AFF, 1'b1));
    @(negedge clk);
    ia.in_valid = 1'b0;
    total++; if (ia.rf_en !== 1'b1 || ia.rf_imm !== 16'hFFFF || ia.rf_reg3 !== 3'd0) begin bad++;
      $display("FAIL imm_sext: got rf_en=%b imm=%h reg3=%0d want 1 ffff 0", ia.rf_en, ia.rf_imm, ia.rf_reg3); end
    repeat (2) @(negedge clk);
    if (ia.out_valid === 1'b1 && sb_a.size() > 0) begin
      exp = sb_a.pop_front();
      total++; if ({ia.out_err, ia.out_result} !== exp) begin bad++;
        $display("FAIL imm_sext_result: got err=%b res=%h want err=%b res=%h", ia.out_err, ia.out_result, exp[16], exp[15:0]); end
    end else begin
      total++; bad++;
      $display("FAIL imm_sext_latency: got out_valid=%b want 1", ia.out_valid);
    end
    // Zero-extending instance, latency 4
    @(negedge clk);
    ib.in_instr = 16'h2AFF; ib.in_valid = 1'b1;
    sb_b.push_back(model(16'h2AFF, 1'b0));
    @(negedge clk);
    ib.in_valid = 1'b0;
    total++; if (ib.rf_en !== 1'b1 || ib.rf_imm !== 16'h007F || ib.rf_reg3 !== 3'd0) begin bad++;
      $display("FAIL imm_zext: got rf_en=%b imm=%h reg3=%0d want 1 007f 0", ib.rf_en, ib.rf_imm, ib.rf_reg3); end
    lat = 0;
    for (int k = 2; k < 14 && lat == 0; k++) begin
      @(negedge clk);
      if (ib.out_valid === 1'b1) lat = k;
    end
    total++; if (lat !== 6) begin bad++;
      $display("FAIL imm_zext_latency: got %0d cycles want 6", lat); end
    if (lat != 0 && sb_b.size() > 0) begin
      exp = sb_b.pop_front();
      total++; if ({ib.out_err, ib.out_result} !== exp) begin bad++;
        $display("FAIL imm_zext_result: got err=%b res=%h want err=%b res=%h", ib.out_err, ib.out_result, exp[16], exp[15:0]); end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_imm();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
